uart_rx_os: RTL and testbench

//  Parametrised oversampling UART receiver, successor to the fixed 8N1 receiver.

---
 rtl/uart_rx_os.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_os.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with majority vote and error flags
//
// Purpose: receives asynchronous serial frames (start, DATA_BITS LSB first,
// optional parity, STOP_BITS stop bits) at OVERSAMPLE samples per bit. Each
// bit value is the 2-of-3 majority of the samples around mid-bit. The received
// word is held on a valid/ready interface together with its error flags.
//
// Ports:
//   clk         system clock
//   rst_n       synchronous reset, active low
//   rx          asynchronous serial line, idle high
//   data        received word, stable while data_valid=1
//   data_valid  word available, held until data_valid&data_ready
//   data_ready  consumer accept
//   parity_err  parity mismatch for the word in data
//   frame_err   a stop bit was sampled low for the word in data
//   overrun     1-cycle pulse: a frame completed while a word was still held
//   busy        receiver is inside a frame
module uart_rx_os #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_BITS);

  localparam logic [TW-1:0] T_LAST    = TW'(DIV - 1);
  localparam logic [SW-1:0] SC_V0     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SC_V1     = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SC_V2     = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] SC_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_nx;
  logic                 rx_m, rx_s;
  logic [TW-1:0]        tcnt;
  logic [SW-1:0]        sc;
  logic [1:0]           smp;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 fe_acc;
  logic                 tick, vote_now, wrap, vote, done;
  logic                 par_xor, par_err_calc;

  // The tick divider is parked in IDLE so every frame starts phase-aligned
  // to the detected start edge.
  assign tick     = (state != S_IDLE) && (tcnt == T_LAST);
  assign vote_now = tick && (sc == SC_V2);
  assign wrap     = tick && (sc == SC_LAST);
  assign vote     = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
  // Completion happens at the mid-bit vote of the last stop bit so the
  // receiver is back in IDLE early enough to catch a back-to-back start edge.
  assign done     = (state == S_STOP) && vote_now && (stop_cnt == STOP_LAST);
  assign busy     = (state != S_IDLE);

  assign par_xor      = ^{shreg, par_bit};
  assign par_err_calc = (PARITY == 1) ? ~par_xor : ((PARITY == 2) ? par_xor : 1'b0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (!rx_s) state_nx = S_START;
      S_START: begin
        if (vote_now && vote) state_nx = S_IDLE;
        else if (wrap)        state_nx = S_DATA;
      end
      S_DATA:   if (wrap && (bit_cnt == BIT_LAST))
                  state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (wrap) state_nx = S_STOP;
      S_STOP:   if (done) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt       <= '0;
      sc         <= '0;
      smp        <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      fe_acc     <= 1'b0;
      data       <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (state == S_IDLE) begin
        tcnt     <= '0;
        sc       <= '0;
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        fe_acc   <= 1'b0;
      end else begin
        tcnt <= tick ? '0 : tcnt + 1'b1;
        if (tick) sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
        if (tick && (sc == SC_V0)) smp[0] <= rx_s;
        if (tick && (sc == SC_V1)) smp[1] <= rx_s;
        if ((state == S_DATA) && vote_now) shreg <= {vote, shreg[DATA_BITS-1:1]};
        if ((state == S_DATA) && wrap) bit_cnt <= bit_cnt + 1'b1;
        if ((state == S_PARITY) && vote_now) par_bit <= vote;
        if ((state == S_STOP) && vote_now && !vote) fe_acc <= 1'b1;
        if ((state == S_STOP) && wrap) stop_cnt <= stop_cnt + 1'b1;
      end

      if (done) begin
        if (!data_valid || data_ready) begin
          data       <= shreg;
          parity_err <= par_err_calc;
          frame_err  <= fe_acc | ~vote;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - directed self-checking bench for uart_rx_os
module tb_uart_rx_os;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_p = 1'b1;
  logic       data_ready = 1'b1;
  logic [7:0] data, data_p;
  logic       data_valid, data_valid_p;
  logic       parity_err, parity_err_p;
  logic       frame_err, frame_err_p;
  logic       overrun, overrun_p;
  logic       busy, busy_p;

  int total = 0;
  int bad = 0;

  int         acc = 0, dvc = 0, ovr_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_pe = 1'b0, last_fe = 1'b0;
  int         acc_p = 0;
  logic [7:0] last_data_p = 8'h00;
  logic       last_pe_p = 1'b0;

  always #5 clk = ~clk;

  uart_rx_os #(.CLK_FREQ(1_843_200), .BAUD_RATE(115200), .OVERSAMPLE(16),
               .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data(data), .data_valid(data_valid),
    .data_ready(data_ready), .parity_err(parity_err), .frame_err(frame_err),
    .overrun(overrun), .busy(busy));

  uart_rx_os #(.CLK_FREQ(1_843_200), .BAUD_RATE(115200), .OVERSAMPLE(16),
               .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut_p (
    .clk(clk), .rst_n(rst_n), .rx(rx_p), .data(data_p), .data_valid(data_valid_p),
    .data_ready(1'b1), .parity_err(parity_err_p), .frame_err(frame_err_p),
    .overrun(overrun_p), .busy(busy_p));

  always @(negedge clk) begin
    if (data_valid && data_ready) begin
      acc       <= acc + 1;
      last_data <= data;
      last_pe   <= parity_err;
      last_fe   <= frame_err;
    end
    if (data_valid) dvc <= dvc + 1;
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (data_valid_p) begin
      acc_p       <= acc_p + 1;
      last_data_p <= data_p;
      last_pe_p   <= parity_err_p;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Drives bits LSB first, 16 clocks per bit; gbit selects a bit that gets a
  // one-clock inverted glitch near its middle (-1 for none).
  task automatic send(input int line, input logic [15:0] bits, input int n, input int gbit);
    logic v;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 16; i++) begin
        v = bits[k];
        if (k == gbit && i == 9) v = ~v;
        if (line == 0) rx = v;
        else           rx_p = v;
        idle(1);
      end
    end
    rx   = 1'b1;
    rx_p = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_valid", 32'(data_valid), 32'h0);
    chk("rst_perr", 32'(parity_err), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    idle(5);

    // 8N1 0xA5 with ready held high
    send(0, {6'b111111, 1'b1, 8'hA5, 1'b0}, 10, -1);
    idle(20);
    chk("t1_acc", acc, 1);
    chk("t1_valid_cycles", dvc, 1);
    chk("t1_data", 32'(last_data), 32'hA5);
    chk("t1_perr", 32'(last_pe), 32'h0);
    chk("t1_ferr", 32'(last_fe), 32'h0);
    chk("t1_busy", 32'(busy), 32'h0);
    chk("t1_ovr", ovr_cnt, 0);

    // even parity: 0x03 with wrong then right parity bit
    send(1, {5'b11111, 1'b1, 1'b1, 8'h03, 1'b0}, 11, -1);
    idle(20);
    chk("t2_acc_a", acc_p, 1);
    chk("t2_data_a", 32'(last_data_p), 32'h03);
    chk("t2_perr_a", 32'(last_pe_p), 32'h1);
    send(1, {5'b11111, 1'b1, 1'b0, 8'h03, 1'b0}, 11, -1);
    idle(20);
    chk("t2_acc_b", acc_p, 2);
    chk("t2_data_b", 32'(last_data_p), 32'h03);
    chk("t2_perr_b", 32'(last_pe_p), 32'h0);

    // stop bit low, then a clean frame
    send(0, {6'b111111, 1'b0, 8'h55, 1'b0}, 10, -1);
    idle(40);
    chk("t3_acc_a", acc, 2);
    chk("t3_data_a", 32'(last_data), 32'h55);
    chk("t3_ferr_a", 32'(last_fe), 32'h1);
    send(0, {6'b111111, 1'b1, 8'h3C, 1'b0}, 10, -1);
    idle(20);
    chk("t3_acc_b", acc, 3);
    chk("t3_data_b", 32'(last_data), 32'h3C);
    chk("t3_ferr_b", 32'(last_fe), 32'h0);

    // short false start, then a glitch inside a data bit
    rx = 1'b0;
    idle(4);
    chk("t4_busy_in", 32'(busy), 32'h1);
    rx = 1'b1;
    idle(10);
    chk("t4_busy_out", 32'(busy), 32'h0);
    idle(20);
    chk("t4_no_word", acc, 3);
    send(0, {6'b111111, 1'b1, 8'hF0, 1'b0}, 10, 1);
    idle(20);
    chk("t4_acc", acc, 4);
    chk("t4_data", 32'(last_data), 32'hF0);

    // hold off the consumer: second word is dropped with an overrun pulse
    data_ready = 1'b0;
    send(0, {6'b111111, 1'b1, 8'h11, 1'b0}, 10, -1);
    idle(20);
    chk("t5_valid_a", 32'(data_valid), 32'h1);
    chk("t5_data_a", 32'(data), 32'h11);
    send(0, {6'b111111, 1'b1, 8'h22, 1'b0}, 10, -1);
    idle(20);
    chk("t5_valid_b", 32'(data_valid), 32'h1);
    chk("t5_data_b", 32'(data), 32'h11);
    chk("t5_ovr_cycles", ovr_cnt, 1);
    data_ready = 1'b1;
    idle(1);
    chk("t5_valid_clr", 32'(data_valid), 32'h0);
    idle(5);
    chk("t5_acc", acc, 5);
    chk("t5_acc_data", 32'(last_data), 32'h11);
    chk("t5_data_kept", 32'(data), 32'h11);

    // reset in the middle of a frame
    send(0, {6'b111111, 1'b1, 8'h77, 1'b0}, 4, -1);
    rst_n = 1'b0;
    idle(2);
    chk("t6_data", 32'(data), 32'h0);
    chk("t6_valid", 32'(data_valid), 32'h0);
    chk("t6_perr", 32'(parity_err), 32'h0);
    chk("t6_ferr", 32'(frame_err), 32'h0);
    chk("t6_ovr", 32'(overrun), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    idle(40);
    chk("t6_no_word", acc, 5);
    send(0, {6'b111111, 1'b1, 8'h88, 1'b0}, 10, -1);
    idle(20);
    chk("t6_acc", acc, 6);
    chk("t6_next_data", 32'(last_data), 32'h88);
    chk("t6_next_ferr", 32'(last_fe), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
